dropout_mask_gen: RTL and testbench

- Generates the per-lane keep/drop mask consumed directly by the downstream dropout stage, using a synthesizable Galois LFSR in place of simulation-only random calls.
- On request, produces one N-bit mask, one lane per cycle. A lane is dropped when its LFSR sample is below a programmable threshold, so the drop probability is drop_thresh/65536.
- Completed mask is held behind a valid/ready handshake until the consumer takes it.

---
 rtl/dropout_pkg.sv | 16 +
 rtl/lfsr_galois_step.sv | 17 +
 rtl/dropout_mask_gen.sv | 91 +++++++++
 tb/tb_dropout_mask_gen.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dropout_pkg.sv
// Shared constants for the dropout mask generator and the downstream dropout stage.
package dropout_pkg;

  localparam int N      = 8;
  localparam int LFSR_W = 16;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/lfsr_galois_step.sv
// One step of a right-shifting Galois LFSR; purely combinational.
module lfsr_galois_step
  import dropout_pkg::*;
#(
  parameter int              W    = 16,
  parameter logic [W-1:0]    TAPS = W'(LFSR_TAPS)
) (
  input  logic [W-1:0] lfsr,
  output logic [W-1:0] next
);

  always_comb begin
    next = lfsr >> 1;
    if (lfsr[0]) next = next ^ TAPS;
  end

endmodule

// File: rtl/dropout_mask_gen.sv
// Dropout keep/drop mask generator: one lane per cycle from a Galois LFSR,
// result held behind a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for req_valid; seed_load honoured here only
// GEN   | stepping LFSR, writing one mask lane per cycle
// HOLD  | mask_valid high, mask frozen until mask_ready
module dropout_mask_gen #(
  parameter int                N            = dropout_pkg::N,
  parameter int                LFSR_W       = dropout_pkg::LFSR_W,
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = LFSR_W'(dropout_pkg::SEED_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic [LFSR_W-1:0] drop_thresh,
  input  logic              req_valid,
  output logic              req_ready,
  output logic              mask_valid,
  input  logic              mask_ready,
  output logic [N-1:0]      mask,
  output logic              busy
);
  import dropout_pkg::*;

  localparam int LANE_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N - 1);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_GEN  = ST_GEN;
  localparam logic [1:0] S_HOLD = ST_HOLD;

  logic [1:0]        state;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_next;
  logic [LFSR_W-1:0] thresh;
  logic [LFSR_W-1:0] seed_fix;
  logic [LANE_W-1:0] lane;

  lfsr_galois_step #(
    .W    (LFSR_W),
    .TAPS (LFSR_W'(LFSR_TAPS))
  ) u_step (
    .lfsr (lfsr),
    .next (lfsr_next)
  );

  // A zero seed would lock the LFSR, so it is replaced by the default.
  assign seed_fix = (seed == '0) ? SEED_DEFAULT : seed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      lfsr   <= SEED_DEFAULT;
      mask   <= '0;
      lane   <= '0;
      thresh <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (seed_load) lfsr <= seed_fix;
          if (req_valid) begin
            thresh <= drop_thresh;
            mask   <= '0;
            lane   <= '0;
            state  <= S_GEN;
          end
        end
        S_GEN: begin
          lfsr       <= lfsr_next;
          mask[lane] <= !(lfsr_next < thresh);
          if (lane == LAST_LANE) begin
            state <= S_HOLD;
          end else begin
            lane <= lane + LANE_W'(1);
          end
        end
        S_HOLD: begin
          if (mask_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state == S_IDLE);
  assign mask_valid = (state == S_HOLD);
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_dropout_mask_gen.sv
// Self-checking bench for dropout_mask_gen: vector table, corner sequences,
// randomized traffic against a sample-by-sample reference model.
module tb_dropout_mask_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed = 16'h0;
  logic [15:0] drop_thresh = 16'h0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        mask_valid;
  logic        mask_ready = 1'b0;
  logic [7:0]  mask;
  logic        busy;

  logic [15:0] step_in = 16'h0;
  logic [15:0] step_out;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] model_lfsr = 16'hACE1;
  bit          saw_zero = 1'b0;

  typedef struct {
    logic [15:0] thresh;
    logic [1:0]  load_mode;  // 0 none, 1 seed_load a cycle before req, 2 together with req
    logic [15:0] seed;
    logic        has_exp;
    logic [7:0]  exp_mask;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  dropout_mask_gen #(
    .N            (8),
    .LFSR_W       (16),
    .SEED_DEFAULT (16'hACE1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seed_load   (seed_load),
    .seed        (seed),
    .drop_thresh (drop_thresh),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .mask_valid  (mask_valid),
    .mask_ready  (mask_ready),
    .mask        (mask),
    .busy        (busy)
  );

  lfsr_galois_step #(.W(16), .TAPS(16'hB400)) u_step (.lfsr(step_in), .next(step_out));

  always @(negedge clk) if (dut.lfsr == 16'h0) saw_zero = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Galois step as an arithmetic rule: halve, and fold in the taps when odd.
  function automatic logic [15:0] ref_step(input logic [15:0] x);
    logic [15:0] h;
    h = x / 2;
    return (x % 2 == 1) ? (h ^ 16'hB400) : h;
  endfunction

  task automatic model_seed(input logic [15:0] sd);
    model_lfsr = (sd == 16'h0) ? 16'hACE1 : sd;
  endtask

  // Lane i is kept when its sample is not below the threshold.
  task automatic model_gen(input logic [15:0] th, output logic [7:0] m);
    m = 8'h0;
    for (int i = 0; i < 8; i++) begin
      model_lfsr = ref_step(model_lfsr);
      if (model_lfsr >= th) m[i] = 1'b1;
    end
  endtask

  task automatic start_req(input logic [15:0] th, input logic [1:0] mode, input logic [15:0] sd);
    @(negedge clk);
    if (mode == 2'd1) begin
      seed_load = 1'b1;
      seed = sd;
      @(negedge clk);
      seed_load = 1'b0;
      seed = 16'($urandom);
    end else if (mode == 2'd2) begin
      seed_load = 1'b1;
      seed = sd;
    end
    check("req_ready_idle", {31'b0, req_ready}, 1);
    drop_thresh = th;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    seed_load = 1'b0;
    drop_thresh = 16'($urandom);
    seed = 16'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!mask_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic accept();
    @(negedge clk);
    mask_ready = 1'b1;
    @(posedge clk);
    #1;
    mask_ready = 1'b0;
  endtask

  task automatic run_one(input logic [15:0] th, input logic [1:0] mode, input logic [15:0] sd,
                         input int dly, output logic [7:0] m, output int lat);
    start_req(th, mode, sd);
    wait_valid(lat);
    m = mask;
    repeat (dly) @(posedge clk);
    #1;
    check("mask_hold_stable", {24'b0, mask}, {24'b0, m});
    accept();
  endtask

  initial begin
    logic [15:0] samples[8];
    logic [7:0]  exp_m;
    logic [7:0]  got;
    logic [7:0]  held;
    int          lat;
    int          drops;
    int          lanes;
    int          permille;
    logic [15:0] th;
    logic [1:0]  mode;
    logic [15:0] sd;

    samples = '{16'hE270, 16'h7138, 16'h389C, 16'h1C4E, 16'h0E27, 16'hB313, 16'hED89, 16'hC2C4};

    vecs[0] = '{16'h8000, 2'd0, 16'h0000, 1'b1, 8'hE1};
    vecs[1] = '{16'h0000, 2'd0, 16'h0000, 1'b1, 8'hFF};
    vecs[2] = '{16'h8000, 2'd1, 16'h0000, 1'b1, 8'hE1};
    vecs[3] = '{16'h8000, 2'd2, 16'h0000, 1'b1, 8'hE1};
    vecs[4] = '{16'hFFFF, 2'd1, 16'hACE1, 1'b1, 8'h00};
    vecs[5] = '{16'hE271, 2'd2, 16'hACE1, 1'b1, 8'h40};
    vecs[6] = '{16'hE270, 2'd1, 16'hACE1, 1'b1, 8'h41};
    vecs[7] = '{16'h0001, 2'd2, 16'h0001, 1'b1, 8'hFF};
    vecs[8] = '{16'h8000, 2'd1, 16'h1234, 1'b0, 8'h00};
    vecs[9] = '{16'hFFFF, 2'd0, 16'h0000, 1'b0, 8'h00};

    step_in = 16'hACE1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("step_chain", {16'b0, step_out}, {16'b0, samples[i]});
      step_in = step_out;
    end
    for (int i = 0; i < 30; i++) begin
      step_in = 16'($urandom);
      #1;
      check("step_rand", {16'b0, step_out}, {16'b0, ref_step(step_in)});
    end

    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 1);
    check("rst_mask_valid", {31'b0, mask_valid}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_mask", {24'b0, mask}, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].load_mode != 2'd0) model_seed(vecs[i].seed);
      model_gen(vecs[i].thresh, exp_m);
      run_one(vecs[i].thresh, vecs[i].load_mode, vecs[i].seed, i % 3, got, lat);
      check("vec_latency", lat, 8);
      check("vec_mask_model", {24'b0, got}, {24'b0, exp_m});
      if (vecs[i].has_exp) check("vec_mask_const", {24'b0, got}, {24'b0, vecs[i].exp_mask});
    end

    // Backpressure: 20 cycles in HOLD with stray req_valid / seed_load.
    model_gen(16'h8000, exp_m);
    start_req(16'h8000, 2'd0, 16'h0);
    check("gen_busy", {31'b0, busy}, 1);
    check("gen_not_valid", {31'b0, mask_valid}, 0);
    wait_valid(lat);
    check("bp_latency", lat, 8);
    held = mask;
    check("bp_mask_model", {24'b0, held}, {24'b0, exp_m});
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      req_valid = 1'b1;
      seed_load = 1'b1;
      seed = 16'($urandom);
      drop_thresh = 16'($urandom);
      check("bp_mask_stable", {24'b0, mask}, {24'b0, held});
      check("bp_req_ready_low", {31'b0, req_ready}, 0);
      check("bp_valid_high", {31'b0, mask_valid}, 1);
    end
    @(negedge clk);
    req_valid = 1'b0;
    seed_load = 1'b0;
    accept();
    model_gen(16'h8000, exp_m);
    run_one(16'h8000, 2'd0, 16'h0, 0, got, lat);
    check("bp_next_mask", {24'b0, got}, {24'b0, exp_m});

    // Reset pulse during GEN lane 3.
    start_req(16'h8000, 2'd0, 16'h0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstgen_mask_valid", {31'b0, mask_valid}, 0);
    check("rstgen_mask", {24'b0, mask}, 0);
    check("rstgen_busy", {31'b0, busy}, 0);
    check("rstgen_req_ready", {31'b0, req_ready}, 1);
    @(negedge clk);
    rst_n = 1'b1;
    model_seed(16'hACE1);
    model_gen(16'h8000, exp_m);
    run_one(16'h8000, 2'd0, 16'h0, 1, got, lat);
    check("rstgen_next_e1", {24'b0, got}, 32'hE1);
    check("rstgen_next_model", {24'b0, got}, {24'b0, exp_m});

    // Reset pulse during HOLD drops mask_valid without a clock edge.
    start_req(16'h0000, 2'd0, 16'h0);
    wait_valid(lat);
    check("rsthold_valid_before", {31'b0, mask_valid}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rsthold_mask_valid", {31'b0, mask_valid}, 0);
    check("rsthold_mask", {24'b0, mask}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_seed(16'hACE1);

    // Randomized thresholds, reseeds and consumer delays.
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 5))
        0: th = 16'h0000;
        1: th = 16'hFFFF;
        default: th = 16'($urandom);
      endcase
      mode = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
      sd = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      if (mode != 2'd0) model_seed(sd);
      model_gen(th, exp_m);
      run_one(th, mode, sd, $urandom_range(0, 3), got, lat);
      check("rand_latency", lat, 8);
      check("rand_mask", {24'b0, got}, {24'b0, exp_m});
    end

    // Drop-rate measurement at threshold 0x4000.
    drops = 0;
    lanes = 0;
    for (int k = 0; k < 4000; k++) begin
      model_gen(16'h4000, exp_m);
      run_one(16'h4000, 2'd0, 16'h0, 0, got, lat);
      check("frac_mask", {24'b0, got}, {24'b0, exp_m});
      for (int b = 0; b < 8; b++) if (!got[b]) drops++;
      lanes += 8;
    end
    permille = (drops * 1000) / lanes;
    n_cmp++;
    if (permille < 240 || permille > 260) begin
      n_err++;
      $display("FAIL drop_fraction: got %0d permille, expected 250 +/- 10", permille);
    end
    check("lfsr_never_zero", {31'b0, saw_zero}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
